fft_mag_collector: RTL and testbench

Receive-side endpoint for the FFT core's master_source stream. Captures each output frame (real, imaginary, block exponent, sop/eop), checks framing against the configured transform length, computes the squared magnitude per bin and queues it in a small FIFO toward the downstream A-line processing. The block owns master_source_dav, throttling the core so no sample is lost under downstream backpressure.

---
 rtl/fft_stream_pkg.sv | 22 ++
 rtl/fft_mag_fifo.sv | 50 +++++
 rtl/fft_mag_collector.sv | 209 ++++++++++++++++++++
 tb/tb_fft_mag_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and defaults for the FFT output stream collector.
package fft_stream_pkg;

  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_EW     = 6;
  localparam int unsigned DEF_OW     = 32;
  // Three pipeline stages in flight plus one word the core may still deliver after dav drops.
  localparam int unsigned DAV_MARGIN = 4;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DEF_EW-1:0] blk_exp;
    logic [DEF_OW-1:0] mag;
  } fifo_word_t;

  typedef enum logic {
    StIdle,
    StInFrame
  } frame_state_e;

endpackage

// File: rtl/fft_mag_fifo.sv
// Synchronous show-ahead FIFO; a write into a full FIFO is taken only alongside a read.
module fft_mag_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   free
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign full    = (count_q == (AW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign free    = (AW+1)'(Depth) - count_q;
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | pop);
  assign rd_data = mem_q[rd_ptr_q];

  // Storage array, no reset needed: contents are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fft_mag_collector.sv
// FFT master_source receiver: framing check, squared magnitude pipeline, output FIFO, dav throttle.
module fft_mag_collector
  import fft_stream_pkg::*;
#(
  parameter int unsigned FFT_LEN = 1024,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned EW      = DEF_EW,
  parameter int unsigned OW      = DEF_OW,
  parameter int unsigned DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          master_source_ena,
  input  logic          master_source_sop,
  input  logic          master_source_eop,
  input  logic [DW-1:0] fft_real_out,
  input  logic [DW-1:0] fft_imag_out,
  input  logic [EW-1:0] exponent_out,
  output logic          master_source_dav,
  output logic [OW-1:0] mag_data,
  output logic [EW-1:0] mag_exp,
  output logic          mag_sop,
  output logic          mag_eop,
  output logic          mag_valid,
  input  logic          mag_ready,
  output logic          frame_err,
  output logic          overflow,
  output logic [15:0]   frame_count
);

  localparam int unsigned CW  = $clog2(FFT_LEN);
  localparam int unsigned SW  = 2 * DW + 1;
  localparam int unsigned FW  = OW + EW + 2;
  localparam int unsigned AW1 = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LastBin = CW'(FFT_LEN - 1);

  frame_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, err_d, done;
  logic [EW-1:0] blk_exp_q;
  logic          frame_err_q, overflow_q, dav_q;
  logic [15:0]   frame_count_q;

  logic                 s1_valid_q, s1_sop_q, s1_eop_q;
  logic signed [DW-1:0] s1_re_q, s1_im_q;
  logic [EW-1:0]        s1_exp_q;
  logic                 s2_valid_q, s2_sop_q, s2_eop_q;
  logic [2*DW-1:0]      s2_re2_q, s2_im2_q;
  logic [EW-1:0]        s2_exp_q;
  logic                 s3_valid_q, s3_sop_q, s3_eop_q;
  logic [OW-1:0]        s3_mag_q;
  logic [EW-1:0]        s3_exp_q;

  logic signed [2*DW-1:0] re_ext, im_ext;
  logic [SW-1:0]          sum;
  logic [OW-1:0]          mag_d;
  logic [FW-1:0]          head;
  logic                   full, empty, pop, push_ok;
  logic [AW1-1:0]         free, free_nxt;

  // Framing decision for the word presented this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    if (master_source_ena) begin
      case (state_q)
        StIdle: begin
          if (master_source_sop && !master_source_eop) begin
            state_d = StInFrame;
            cnt_d   = CW'(1);
            accept  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        StInFrame: begin
          if (master_source_sop) begin
            // Early sop restarts the frame; the word becomes bin 0 of the new frame.
            err_d  = 1'b1;
            cnt_d  = CW'(1);
            accept = 1'b1;
          end else if (master_source_eop) begin
            state_d = StIdle;
            accept  = 1'b1;
            if (cnt_q == LastBin) done  = 1'b1;
            else                  err_d = 1'b1;
          end else if (cnt_q == LastBin) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            accept = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Framing state, frame exponent and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      blk_exp_q     <= '0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= err_d;
      if (accept && master_source_sop) blk_exp_q <= exponent_out;
      if (done) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign re_ext = (2*DW)'(s1_re_q);
  assign im_ext = (2*DW)'(s1_im_q);
  assign sum    = SW'(s2_re2_q) + SW'(s2_im2_q);
  // Only the full-scale negative corner reaches 2^(OW-1); it is clamped to all-ones.
  assign mag_d  = (|(sum >> (OW - 1))) ? '1 : OW'(sum);

  // Three-stage squarer pipeline: capture, square, sum and clamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_exp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_re2_q   <= '0;
      s2_im2_q   <= '0;
      s2_exp_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_sop_q   <= 1'b0;
      s3_eop_q   <= 1'b0;
      s3_mag_q   <= '0;
      s3_exp_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sop_q <= master_source_sop;
        s1_eop_q <= master_source_eop;
        s1_re_q  <= fft_real_out;
        s1_im_q  <= fft_imag_out;
        s1_exp_q <= master_source_sop ? exponent_out : blk_exp_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_sop_q   <= s1_sop_q;
      s2_eop_q   <= s1_eop_q;
      s2_re2_q   <= re_ext * re_ext;
      s2_im2_q   <= im_ext * im_ext;
      s2_exp_q   <= s1_exp_q;
      s3_valid_q <= s2_valid_q;
      s3_sop_q   <= s2_sop_q;
      s3_eop_q   <= s2_eop_q;
      s3_mag_q   <= mag_d;
      s3_exp_q   <= s2_exp_q;
    end
  end

  fft_mag_fifo #(
    .Width (FW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s3_valid_q),
    .wr_data ({s3_sop_q, s3_eop_q, s3_exp_q, s3_mag_q}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .free    (free)
  );

  assign pop      = ~empty & mag_ready;
  assign push_ok  = s3_valid_q & (~full | pop);
  assign free_nxt = free - AW1'(push_ok) + AW1'(pop);

  // dav follows the post-edge free count; overflow latches any word the FIFO refused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dav_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dav_q <= (free_nxt >= AW1'(DAV_MARGIN));
      if (s3_valid_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign master_source_dav = dav_q;
  assign mag_valid         = ~empty;
  assign mag_data          = empty ? '0 : head[OW-1:0];
  assign mag_exp           = empty ? '0 : head[OW+EW-1:OW];
  assign mag_eop           = ~empty & head[OW+EW];
  assign mag_sop           = ~empty & head[OW+EW+1];
  assign frame_err         = frame_err_q;
  assign overflow          = overflow_q;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_fft_mag_collector.sv
// Scoreboard bench for fft_mag_collector with an 8-point frame length.
module tb_fft_mag_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena, sop, eop;
  logic [15:0] re, im;
  logic [5:0]  ex;
  logic        dav;
  logic [31:0] mag_data;
  logic [5:0]  mag_exp;
  logic        mag_sop, mag_eop, mag_valid, mag_ready;
  logic        frame_err, overflow;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  logic [39:0] sb[$];

  fft_mag_collector #(
    .FFT_LEN (8),
    .DW      (16),
    .EW      (6),
    .OW      (32),
    .DEPTH   (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .master_source_ena (ena),
    .master_source_sop (sop),
    .master_source_eop (eop),
    .fft_real_out      (re),
    .fft_imag_out      (im),
    .exponent_out      (ex),
    .master_source_dav (dav),
    .mag_data          (mag_data),
    .mag_exp           (mag_exp),
    .mag_sop           (mag_sop),
    .mag_eop           (mag_eop),
    .mag_valid         (mag_valid),
    .mag_ready         (mag_ready),
    .frame_err         (frame_err),
    .overflow          (overflow),
    .frame_count       (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word for one edge; keep=1 records the magnitude word the FIFO should later show.
  task automatic send(input logic s, input logic e, input logic [15:0] r, input logic [15:0] i,
                      input logic [5:0] x, input bit keep, input logic [5:0] fexp,
                      input logic [31:0] mag);
    ena = 1'b1; sop = s; eop = e; re = r; im = i; ex = x;
    if (keep) sb.push_back({s, e, fexp, mag});
    @(posedge clk);
    #1;
    ena = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  // Monitor: every transfer on the output side is checked against the queue head.
  initial begin
    logic [39:0] got, want;
    forever begin
      @(negedge clk);
      if (reset && mag_valid && mag_ready) begin
        got = {mag_sop, mag_eop, mag_exp, mag_data};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", got);
        end else begin
          want = sb.pop_front();
          chk("mag_word", {24'd0, got}, {24'd0, want});
        end
      end
    end
  end

  initial begin
    logic [31:0] tbl2k2 [8];
    int sent;
    int b;
    tbl2k2 = '{32'd0, 32'd2, 32'd8, 32'd18, 32'd32, 32'd50, 32'd72, 32'd98};
    reset = 1'b0; ena = 1'b0; sop = 1'b0; eop = 1'b0;
    re = '0; im = '0; ex = '0; mag_ready = 1'b1;

    // Reset values.
    #23;
    chk("rst_dav", dav, 0);
    chk("rst_valid", mag_valid, 0);
    chk("rst_data", mag_data, 0);
    chk("rst_exp", mag_exp, 0);
    chk("rst_sop_eop", {mag_sop, mag_eop}, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_count", frame_count, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("dav_before_edge", dav, 0);
    @(posedge clk);
    #1;
    chk("dav_first_edge", dav, 1);

    // Frame re=k, im=-k, exponent -3 latched at sop; later exponent_out changes are ignored.
    for (int k = 0; k < 8; k++) begin
      send(k == 0, k == 7, 16'(k), 16'(-k), (k == 0) ? 6'(-3) : 6'(k), 1'b1, 6'(-3), tbl2k2[k]);
      if (k == 1 || k == 2) chk("latency_early", mag_valid, 0);
      if (k == 3) chk("latency_3", mag_valid, 1);
    end
    tick(6);
    exp_fc = 1;
    chk("frame_count_1", frame_count, 16'(exp_fc));
    chk("no_frame_err", frame_err, 0);

    // Saturation corner and full-scale values.
    send(1, 0, 16'h8000, 16'h8000, 6'd5, 1'b1, 6'd5, 32'hFFFF_FFFF);
    send(0, 0, 16'h7FFF, 16'h0000, 6'd5, 1'b1, 6'd5, 32'h3FFF_0001);
    send(0, 0, 16'h0000, 16'h8000, 6'd5, 1'b1, 6'd5, 32'h4000_0000);
    for (int k = 3; k < 8; k++) send(0, k == 7, 16'd0, 16'd0, 6'd5, 1'b1, 6'd5, 32'd0);
    tick(6);
    exp_fc++;
    chk("frame_count_sat", frame_count, 16'(exp_fc));

    // Early eop at bin 5: error pulse, no count; the eop word itself is still queued.
    for (int k = 0; k < 5; k++) send(k == 0, 0, 16'(k), 16'd0, 6'd2, 1'b1, 6'd2, 32'(k * k));
    send(0, 1, 16'd5, 16'd0, 6'd2, 1'b1, 6'd2, 32'd25);
    chk("early_eop_err", frame_err, 1);
    tick(1);
    chk("early_eop_err_pulse", frame_err, 0);
    chk("early_eop_count", frame_count, 16'(exp_fc));

    // sop at bin 3 restarts with a new exponent; the restarted frame completes.
    for (int k = 0; k < 3; k++) send(k == 0, 0, 16'(k), 16'd0, 6'd1, 1'b1, 6'd1, 32'(k * k));
    send(1, 0, 16'd9, 16'd0, 6'd4, 1'b1, 6'd4, 32'd81);
    chk("restart_err", frame_err, 1);
    for (int k = 1; k < 8; k++) send(0, k == 7, 16'(k), 16'd0, 6'd0, 1'b1, 6'd4, 32'(k * k));
    chk("restart_no_err", frame_err, 0);
    tick(6);
    exp_fc++;
    chk("restart_count", frame_count, 16'(exp_fc));

    // Word without sop while idle: error, nothing written.
    send(0, 0, 16'd3, 16'd3, 6'd0, 1'b0, 6'd0, 32'd0);
    chk("idle_nosop_err", frame_err, 1);
    tick(5);
    chk("idle_nosop_nowrite", mag_valid, 0);
    chk("idle_nosop_count", frame_count, 16'(exp_fc));

    // Backpressure with a core that honours dav.
    mag_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (dav) begin
        b = sent % 8;
        send(b == 0, b == 7, 16'(sent), 16'd0, 6'd1, 1'b1, 6'd1, 32'(sent * sent));
        sent++;
      end else begin
        tick(1);
      end
    end
    chk("dav_words_taken", 32'(sent), 16);
    chk("dav_low_when_full", dav, 0);
    chk("dav_no_overflow", overflow, 0);
    chk("dav_fifo_valid", mag_valid, 1);
    mag_ready = 1'b1;
    tick(25);
    chk("dav_drained", 32'(sb.size()), 0);
    chk("dav_back_high", dav, 1);
    exp_fc += 2;
    chk("dav_frame_count", frame_count, 16'(exp_fc));

    // Core ignores dav: the 17th word finds the FIFO full and is dropped.
    mag_ready = 1'b0;
    for (int n = 0; n < 17; n++) begin
      b = n % 8;
      send(b == 0, b == 7, 16'(n + 1), 16'd0, 6'd7, n < 16, 6'd7, 32'((n + 1) * (n + 1)));
    end
    tick(5);
    chk("overflow_set", overflow, 1);
    mag_ready = 1'b1;
    tick(25);
    chk("overflow_sticky", overflow, 1);
    chk("overflow_drained", 32'(sb.size()), 0);
    exp_fc += 2;
    chk("overflow_frame_count", frame_count, 16'(exp_fc));

    // Reset at bin 4 of a frame: everything clears at once.
    for (int k = 0; k < 4; k++) send(k == 0, 0, 16'(k), 16'd0, 6'd3, 1'b1, 6'd3, 32'(k * k));
    ena = 1'b1; re = 16'd4; im = 16'd0;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_valid", mag_valid, 0);
    chk("midrst_data", mag_data, 0);
    chk("midrst_dav", dav, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_count", frame_count, 0);
    sb.delete();
    ena = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++)
      send(k == 0, k == 7, 16'(k), 16'(k), 6'(-1), 1'b1, 6'(-1), tbl2k2[k]);
    tick(8);
    chk("postrst_count", frame_count, 1);
    chk("postrst_overflow", overflow, 0);
    chk("final_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
